// File: rtl/scratchpad_read_sched.sv
// Read-side scheduler for one scratchpad bank: arbitrates DRAM-store and GEMM-fetch
// commands and expands each grant into per-row pushes into the bank's read-request FIFO.
module scratchpad_read_sched #(
    parameter int unsigned MAT_S_W   = 3,
    parameter int unsigned ROW_S_W   = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ROW_BYTES = 8
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               st_valid,
    output logic               st_ready,
    input  logic [MAT_S_W-1:0] st_mat_s,
    input  logic [ADDR_W-1:0]  st_addr,
    output logic               st_done,
    input  logic               gm_valid,
    output logic               gm_ready,
    input  logic [MAT_S_W-1:0] gm_mat_a,
    input  logic [MAT_S_W-1:0] gm_mat_b,
    input  logic [MAT_S_W-1:0] gm_mat_c,
    output logic               gm_done,
    output logic               rreq_wen,
    output logic [1:0]         rreq_mat_t,
    output logic [MAT_S_W-1:0] rreq_mat_s,
    output logic [ROW_S_W-1:0] rreq_row_s,
    output logic [ADDR_W-1:0]  rreq_addr,
    input  logic               rreq_full,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        GEMM  = 2'd2
    } state_t;

    state_t             state;
    logic [ROW_S_W-1:0] row_cnt;
    logic [1:0]         op_idx;
    logic [MAT_S_W-1:0] lat_st_mat;
    logic [MAT_S_W-1:0] lat_a;
    logic [MAT_S_W-1:0] lat_b;
    logic [MAT_S_W-1:0] lat_c;
    logic [ADDR_W-1:0]  lat_base;
    logic               last_gm;

    logic               grant_st;
    logic               grant_gm;
    logic               push;
    logic               last_row;
    logic [MAT_S_W-1:0] op_sel;

    assign last_row = (row_cnt == ROW_S_W'(3));
    assign busy     = (state != IDLE);

    // Arbitration, push qualification and request payload; payload is zero when not pushing.
    always_comb begin
        grant_st   = 1'b0;
        grant_gm   = 1'b0;
        push       = 1'b0;
        op_sel     = lat_c;
        rreq_mat_t = 2'd0;
        rreq_mat_s = '0;
        rreq_row_s = '0;
        rreq_addr  = '0;

        case (op_idx)
            2'd0:    op_sel = lat_a;
            2'd1:    op_sel = lat_b;
            default: op_sel = lat_c;
        endcase

        if (state == IDLE) begin
            grant_st = st_valid && (!gm_valid || last_gm);
            grant_gm = gm_valid && !grant_st;
        end

        push = (state != IDLE) && !rreq_full;

        if (push) begin
            rreq_row_s = row_cnt;
            if (state == STORE) begin
                rreq_mat_t = 2'd0;
                rreq_mat_s = lat_st_mat;
                rreq_addr  = lat_base + ADDR_W'(row_cnt) * ADDR_W'(ROW_BYTES);
            end else begin
                rreq_mat_t = 2'(op_idx + 2'd1);
                rreq_mat_s = op_sel;
            end
        end
    end

    assign st_ready = grant_st;
    assign gm_ready = grant_gm;
    assign rreq_wen = push;

    // State, counters, latched command and done pulses.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            row_cnt    <= '0;
            op_idx     <= 2'd0;
            lat_st_mat <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_c      <= '0;
            lat_base   <= '0;
            last_gm    <= 1'b1;
            st_done    <= 1'b0;
            gm_done    <= 1'b0;
        end else begin
            st_done <= 1'b0;
            gm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_st) begin
                        state      <= STORE;
                        lat_st_mat <= st_mat_s;
                        lat_base   <= st_addr;
                        row_cnt    <= '0;
                        op_idx     <= 2'd0;
                        last_gm    <= 1'b0;
                    end else if (grant_gm) begin
                        state   <= GEMM;
                        lat_a   <= gm_mat_a;
                        lat_b   <= gm_mat_b;
                        lat_c   <= gm_mat_c;
                        row_cnt <= '0;
                        op_idx  <= 2'd0;
                        last_gm <= 1'b1;
                    end
                end
                STORE: begin
                    if (push) begin
                        row_cnt <= row_cnt + ROW_S_W'(1);
                        if (last_row) begin
                            state   <= IDLE;
                            row_cnt <= '0;
                            st_done <= 1'b1;
                        end
                    end
                end
                GEMM: begin
                    if (push) begin
                        row_cnt <= row_cnt + ROW_S_W'(1);
                        if (last_row) begin
                            row_cnt <= '0;
                            if (op_idx == 2'd2) begin
                                state   <= IDLE;
                                op_idx  <= 2'd0;
                                gm_done <= 1'b1;
                            end else begin
                                op_idx <= 2'(op_idx + 2'd1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scratchpad_read_sched.sv
// Directed bench for scratchpad_read_sched: arbitration, row expansion, backpressure, wrap, reset.
module tb_scratchpad_read_sched;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_mat_s;
    logic [31:0] st_addr;
    logic        st_done;
    logic        gm_valid;
    logic        gm_ready;
    logic [2:0]  gm_mat_a;
    logic [2:0]  gm_mat_b;
    logic [2:0]  gm_mat_c;
    logic        gm_done;
    logic        rreq_wen;
    logic [1:0]  rreq_mat_t;
    logic [2:0]  rreq_mat_s;
    logic [1:0]  rreq_row_s;
    logic [31:0] rreq_addr;
    logic        rreq_full;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    scratchpad_read_sched dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_mat_s   (st_mat_s),
        .st_addr    (st_addr),
        .st_done    (st_done),
        .gm_valid   (gm_valid),
        .gm_ready   (gm_ready),
        .gm_mat_a   (gm_mat_a),
        .gm_mat_b   (gm_mat_b),
        .gm_mat_c   (gm_mat_c),
        .gm_done    (gm_done),
        .rreq_wen   (rreq_wen),
        .rreq_mat_t (rreq_mat_t),
        .rreq_mat_s (rreq_mat_s),
        .rreq_row_s (rreq_row_s),
        .rreq_addr  (rreq_addr),
        .rreq_full  (rreq_full),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Expects to be entered just after the grant edge; returns at the negedge of the done cycle.
    task automatic run_store(input logic [2:0] mat, input logic [31:0] base,
                             input int stall_row, input int stall_n);
        logic [31:0] exp_addr;
        for (int r = 0; r < 4; r++) begin
            if (r == stall_row) begin
                rreq_full = 1'b1;
                for (int k = 0; k < stall_n; k++) begin
                    @(negedge CLK);
                    check($sformatf("store stall%0d wen", k), 32'(rreq_wen), 32'd0);
                    check($sformatf("store stall%0d addr", k), rreq_addr, 32'd0);
                    check($sformatf("store stall%0d busy", k), 32'(busy), 32'd1);
                    check($sformatf("store stall%0d done", k), 32'(st_done), 32'd0);
                    next_cycle();
                end
                rreq_full = 1'b0;
            end
            exp_addr = base + 32'(r) * 32'd8;
            @(negedge CLK);
            check($sformatf("store r%0d wen", r), 32'(rreq_wen), 32'd1);
            check($sformatf("store r%0d mat_t", r), 32'(rreq_mat_t), 32'd0);
            check($sformatf("store r%0d mat_s", r), 32'(rreq_mat_s), 32'(mat));
            check($sformatf("store r%0d row_s", r), 32'(rreq_row_s), 32'(r));
            check($sformatf("store r%0d addr", r), rreq_addr, exp_addr);
            check($sformatf("store r%0d done", r), 32'(st_done), 32'd0);
            check($sformatf("store r%0d st_ready", r), 32'(st_ready), 32'd0);
            next_cycle();
        end
        @(negedge CLK);
        check("store done pulse", 32'(st_done), 32'd1);
        check("store done busy", 32'(busy), 32'd0);
        check("store done wen", 32'(rreq_wen), 32'd0);
    endtask

    task automatic run_gemm(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        logic [2:0] sel [3];
        sel[0] = a;
        sel[1] = b;
        sel[2] = c;
        for (int op = 0; op < 3; op++) begin
            for (int r = 0; r < 4; r++) begin
                @(negedge CLK);
                check($sformatf("gemm op%0d r%0d wen", op, r), 32'(rreq_wen), 32'd1);
                check($sformatf("gemm op%0d r%0d mat_t", op, r), 32'(rreq_mat_t), 32'(op + 1));
                check($sformatf("gemm op%0d r%0d mat_s", op, r), 32'(rreq_mat_s), 32'(sel[op]));
                check($sformatf("gemm op%0d r%0d row_s", op, r), 32'(rreq_row_s), 32'(r));
                check($sformatf("gemm op%0d r%0d addr", op, r), rreq_addr, 32'd0);
                check($sformatf("gemm op%0d r%0d done", op, r), 32'(gm_done), 32'd0);
                check($sformatf("gemm op%0d r%0d gm_ready", op, r), 32'(gm_ready), 32'd0);
                next_cycle();
            end
        end
        @(negedge CLK);
        check("gemm done pulse", 32'(gm_done), 32'd1);
        check("gemm done busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST      = 1'b1;
        st_valid  = 1'b0;
        st_mat_s  = 3'd0;
        st_addr   = 32'd0;
        gm_valid  = 1'b0;
        gm_mat_a  = 3'd0;
        gm_mat_b  = 3'd0;
        gm_mat_c  = 3'd0;
        rreq_full = 1'b0;
        #2 nRST   = 1'b0;

        // Reset state
        @(negedge CLK);
        check("reset busy", 32'(busy), 32'd0);
        check("reset wen", 32'(rreq_wen), 32'd0);
        check("reset st_done", 32'(st_done), 32'd0);
        check("reset gm_done", 32'(gm_done), 32'd0);
        check("reset addr", rreq_addr, 32'd0);
        next_cycle();

        // Both valid out of reset: store wins the first tie
        nRST     = 1'b1;
        st_valid = 1'b1;
        st_mat_s = 3'd5;
        st_addr  = 32'h0000_1000;
        gm_valid = 1'b1;
        gm_mat_a = 3'd1;
        gm_mat_b = 3'd2;
        gm_mat_c = 3'd6;
        @(negedge CLK);
        check("tie1 st_ready", 32'(st_ready), 32'd1);
        check("tie1 gm_ready", 32'(gm_ready), 32'd0);
        next_cycle();
        run_store(3'd5, 32'h0000_1000, 4, 0);
        check("tie2 gm_ready", 32'(gm_ready), 32'd1);
        check("tie2 st_ready", 32'(st_ready), 32'd0);
        next_cycle();
        run_gemm(3'd1, 3'd2, 3'd6);
        check("tie3 st_ready", 32'(st_ready), 32'd1);
        check("tie3 gm_ready", 32'(gm_ready), 32'd0);
        next_cycle();

        // Third grant (store) with a 3-cycle stall on row 2
        st_valid = 1'b0;
        gm_valid = 1'b0;
        run_store(3'd5, 32'h0000_1000, 2, 3);
        next_cycle();
        @(negedge CLK);
        check("store done one-shot", 32'(st_done), 32'd0);
        check("idle no ready", 32'(st_ready | gm_ready), 32'd0);
        next_cycle();

        // Address wrap past 2^32
        st_valid = 1'b1;
        st_mat_s = 3'd7;
        st_addr  = 32'hFFFF_FFF8;
        @(negedge CLK);
        check("wrap st_ready", 32'(st_ready), 32'd1);
        next_cycle();
        st_valid = 1'b0;
        run_store(3'd7, 32'hFFFF_FFF8, 4, 0);
        next_cycle();

        // Reset in the middle of a GEMM after 5 pushes
        gm_valid = 1'b1;
        gm_mat_a = 3'd3;
        gm_mat_b = 3'd4;
        gm_mat_c = 3'd5;
        @(negedge CLK);
        check("mid gm_ready", 32'(gm_ready), 32'd1);
        next_cycle();
        gm_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check($sformatf("mid push%0d wen", i), 32'(rreq_wen), 32'd1);
            next_cycle();
        end
        nRST = 1'b0;
        #1;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset wen", 32'(rreq_wen), 32'd0);
        check("mid reset mat_t", 32'(rreq_mat_t), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check($sformatf("mid reset gm_done%0d", i), 32'(gm_done), 32'd0);
            next_cycle();
        end
        nRST     = 1'b1;
        gm_valid = 1'b1;
        gm_mat_a = 3'd2;
        gm_mat_b = 3'd0;
        gm_mat_c = 3'd7;
        @(negedge CLK);
        check("post reset gm_done", 32'(gm_done), 32'd0);
        check("post reset gm_ready", 32'(gm_ready), 32'd1);
        next_cycle();
        gm_valid = 1'b0;
        run_gemm(3'd2, 3'd0, 3'd7);
        next_cycle();
        @(negedge CLK);
        check("gemm done one-shot", 32'(gm_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scratchpad_read_sched.md
# scratchpad_read_sched

Read-side scheduler for one scratchpad bank. It arbitrates between two requesters: the DRAM store engine, which writes a matrix back to memory, and the GEMM issue unit, which fetches the A, B and C operand matrices. Each granted command is expanded into per-row read requests and pushed into the bank's read-request FIFO under its full backpressure. It sits between those requesters and the bank's rFIFO write port.

## Interface

Parameters:
- MAT_S_W, 3: width of the matrix-select field.
- ROW_S_W, 2: width of the row-select field. Rows per matrix are fixed at 4.
- ADDR_W, 32: width of a DRAM byte address.
- ROW_BYTES, 8: address stride between consecutive rows.

Ports (the clock is `CLK`; reset is `nRST`, asynchronous, active-low; one clock domain):
- CLK  in  1  clock.
- nRST  in  1  async active-low reset.
- st_valid  in  1  store command present.
- st_ready  out  1  store command accepted this cycle.
- st_mat_s  in  MAT_S_W  matrix to store.
- st_addr  in  ADDR_W  DRAM base address of row 0.
- st_done  out  1  one-cycle pulse: all 4 store rows issued.
- gm_valid  in  1  GEMM fetch command present.
- gm_ready  out  1  GEMM command accepted this cycle.
- gm_mat_a, gm_mat_b, gm_mat_c  in  MAT_S_W each  operand matrix selects.
- gm_done  out  1  one-cycle pulse: all 12 GEMM rows issued.
- rreq_wen  out  1  push one read request to the bank.
- rreq_mat_t  out  2  0 = DRAM store, 1 = A, 2 = B, 3 = C.
- rreq_mat_s  out  MAT_S_W  matrix select.
- rreq_row_s  out  ROW_S_W  row select.
- rreq_addr  out  ADDR_W  DRAM address; 0 for GEMM requests.
- rreq_full  in  1  bank read-request FIFO full.
- busy  out  1  state != IDLE.

## Operation

- FSM states: IDLE, STORE, GEMM. Registers:
  - row counter (2 bits)
  - operand index (0..2)
  - latched mat selects and base address
  - round-robin pointer (`last_gm`)
  - done pulse registers
- **IDLE, arbitration:**
  - Only st_valid: grant store.
  - Only gm_valid: grant GEMM.
  - Both valid: grant the port not granted last. After reset, store wins the first tie (`last_gm` resets to 1).
  - The grant drives the matching *_ready high combinationally in the same cycle. The command fields are latched at that edge, the counters clear, and the FSM moves to STORE or GEMM. `last_gm` updates at that edge.
  - The *_ready outputs are 0 outside IDLE.
- **STORE:**
  - Each cycle with rreq_full = 0: rreq_wen = 1, mat_t = 0, mat_s = latched st_mat_s, row_s = row counter, addr = base + row × ROW_BYTES (mod 2^ADDR_W). The row counter then increments.
  - After row 3 is pushed: return to IDLE and pulse st_done for exactly the next cycle.
- **GEMM:**
  - Issue order: A rows 0–3, then B rows 0–3, then C rows 0–3. mat_t = operand index + 1, mat_s = the latched select for that operand, addr = 0.
  - After C row 3 is pushed: return to IDLE and pulse gm_done for the next cycle.
- **Backpressure:** rreq_full = 1 → rreq_wen = 0 and the counters hold. There is no request loss or duplication. rreq_wen is combinational from state and rreq_full.
- Commands are non-preemptive. A valid arriving mid-command waits, and its fields must remain stable until *_ready.

## Timing

- Reset values: state IDLE; all counters 0; `last_gm` = 1. Outputs: st_done = 0, gm_done = 0, busy = 0, rreq_wen = 0. rreq_* data fields = 0 whenever rreq_wen = 0.
- Store with no backpressure: accept at edge t, requests in cycles t+1..t+4, st_done high in cycle t+5. In cycle t+5 the state is IDLE and a new grant is legal.
- GEMM with no backpressure: requests t+1..t+12, gm_done in cycle t+13.
- Each cycle of rreq_full stretches the sequence by exactly one cycle.
- The done pulse and a new *_ready may both be high in the same cycle.
- Reset asserted mid-command: the in-flight command is discarded immediately, no done pulse is produced, and all outputs return to reset values asynchronously.

## Test plan

- **Store, no backpressure:** st_mat_s = 5, st_addr = 0x1000 → 4 pushes with row_s 0..3 and addr 0x1000, 0x1008, 0x1010, 0x1018, mat_t = 0; st_done pulses at t+5.
- **GEMM, no backpressure:** A = 1, B = 2, C = 6 → 12 pushes, (mat_t, mat_s) = (1,1)×4, (2,2)×4, (3,6)×4, row_s cycling 0..3; gm_done pulses at t+13.
- **Simultaneous valid:** both asserted from reset → store granted first, then GEMM; with both held continuously, grants alternate store/GEMM/store.
- **Backpressure:** rreq_full high for 3 cycles during store row 2 → row 2 is issued exactly once after full drops; st_done is delayed by 3 cycles.
- **Address wrap:** st_addr = 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0x0, 0x8, 0x10.
- **Reset mid-GEMM:** deassert nRST after 5 GEMM pushes → busy = 0 and rreq_wen = 0 immediately; gm_done never pulses; the next command starts from row 0 of A.
